// File: rtl/multiplier_4bits_divider_if.sv
// Operand/result handshake bundle for the restoring divider.
// The master drives the operands and accepts results. The slave is the divider.
interface multiplier_4bits_divider_if #(
  parameter int WIDTH_N = 8,
  parameter int WIDTH_D = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH_N-1:0] dividend;
  logic [WIDTH_D-1:0] divisor;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH_N-1:0] quotient;
  logic [WIDTH_D-1:0] remainder;
  logic               div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/multiplier_4bits_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock, MSB first.
// This is the divide path that sits beside the 4-bit multipliers.
module multiplier_4bits_divider #(
  parameter int WIDTH_N = 8,
  parameter int WIDTH_D = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  multiplier_4bits_divider_if.slave      bus
);

  localparam int CNT_W = (WIDTH_N > 1) ? $clog2(WIDTH_N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH_N-1:0] dvd_q, dvd_d;
  logic [WIDTH_D-1:0] dsr_q, dsr_d;
  logic [WIDTH_D-1:0] rem_q, rem_d;
  logic [WIDTH_N-1:0] quotient_q, quotient_d;
  logic [WIDTH_D-1:0] remainder_q, remainder_d;
  logic               dbz_q, dbz_d;

  logic [WIDTH_D:0]   r_shift;
  logic               q_bit;
  logic [WIDTH_D-1:0] rem_next;
  logic [WIDTH_N-1:0] dvd_next;

  // dvd_q shifts the dividend out at the top while quotient bits enter at the bottom,
  // so after the last iteration it holds the full quotient.
  always_comb begin
    r_shift  = {rem_q, dvd_q[WIDTH_N-1]};
    q_bit    = (r_shift >= {1'b0, dsr_q});
    rem_next = q_bit ? WIDTH_D'(r_shift - {1'b0, dsr_q}) : r_shift[WIDTH_D-1:0];
    dvd_next = {dvd_q[WIDTH_N-2:0], q_bit};
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    dsr_d       = dsr_q;
    rem_d       = rem_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          dvd_d = bus.dividend;
          dsr_d = bus.divisor;
          rem_d = '0;
          cnt_d = CNT_W'(WIDTH_N - 1);
          if (bus.divisor == '0) begin
            quotient_d  = '1;
            remainder_d = bus.dividend[WIDTH_D-1:0];
            dbz_d       = 1'b1;
            state_d     = DONE;
          end else begin
            state_d = DIV;
          end
        end
      end
      DIV: begin
        dvd_d = dvd_next;
        rem_d = rem_next;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          quotient_d  = dvd_next;
          remainder_d = rem_next;
          dbz_d       = 1'b0;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      dsr_q       <= '0;
      rem_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      dsr_q       <= dsr_d;
      rem_q       <= rem_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  // Handshake outputs decode the registered state only.
  assign bus.in_ready    = (state_q == IDLE);
  assign bus.out_valid   = (state_q == DONE);
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;

endmodule
